// File: rtl/lc_sdram_seq.sv
// lc_sdram_seq: turns language-card RAM strobes into single-byte accesses on a 16-bit SDRAM,
// with power-up init, periodic auto-refresh and a one-deep request slot.
module lc_sdram_seq #(
  parameter int          INIT_WAIT    = 2800,
  parameter int          REF_INTERVAL = 210,
  parameter logic [12:0] MODE_WORD    = 13'h020
) (
  input  logic        mclk28,
  input  logic        reset_in,
  input  logic        strobe,
  input  logic [17:0] ram_addr,
  input  logic        card_ram_we,
  input  logic        card_ram_rd,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        dout_valid,
  output logic        busy,
  output logic        ready,
  output logic        overrun,
  output logic        sd_cke,
  output logic        sd_cs_n,
  output logic        sd_ras_n,
  output logic        sd_cas_n,
  output logic        sd_we_n,
  output logic [1:0]  sd_ba,
  output logic [12:0] sd_addr,
  output logic [1:0]  sd_dqm,
  output logic [15:0] sd_dq_out,
  output logic        sd_dq_oe,
  input  logic [15:0] sd_dq_in
);

  localparam logic [3:0] CMD_DESEL = 4'b1111;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_MRS   = 4'b0000;

  localparam logic [15:0] WAIT_LAST = 16'(INIT_WAIT - 1);
  localparam logic [15:0] REF_LAST  = 16'(REF_INTERVAL - 1);

  typedef enum logic [3:0] {
    S_INIT_WAIT = 4'd0,
    S_INIT_PRE  = 4'd1,
    S_INIT_REF1 = 4'd2,
    S_INIT_REF2 = 4'd3,
    S_INIT_MRS  = 4'd4,
    S_IDLE      = 4'd5,
    S_ACT       = 4'd6,
    S_TRCD      = 4'd7,
    S_RW        = 4'd8,
    S_CL1       = 4'd9,
    S_CL2       = 4'd10,
    S_RECOVER   = 4'd11,
    S_REFRESH   = 4'd12
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [15:0] tcnt;
  logic        entering;
  logic        acc_we;

  logic [15:0] ref_cnt;
  logic        ref_pend;
  logic        ref_run;
  logic        ref_enter;

  logic        slot_full;
  logic        slot_we;
  logic [17:0] slot_addr;
  logic [7:0]  slot_din;
  logic        slot_full_next;
  logic        slot_clear;
  logic        req_valid;
  logic        accept;
  logic        req_we;
  logic [17:0] req_addr;
  logic [7:0]  req_din;

  logic [3:0]  cmd_reg;
  logic [3:0]  cmd_next;
  logic [12:0] addr_next;
  logic [1:0]  dqm_next;
  logic [15:0] dq_out_next;
  logic        dq_oe_next;
  logic        busy_next;

  assign {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} = cmd_reg;
  assign sd_ba = 2'b00;

  // Request qualification; the slot frees on the cycle an access enters RECOVER,
  // so a strobe landing on that cycle is taken instead of being counted as overrun.
  always_comb begin
    req_valid  = strobe & (card_ram_we | card_ram_rd);
    slot_clear = ((state == S_RW) & slot_we) | (state == S_CL2);
    accept     = req_valid & (~slot_full | slot_clear);
    if (slot_full) begin
      req_we   = slot_we;
      req_addr = slot_addr;
      req_din  = slot_din;
    end else begin
      req_we   = card_ram_we;
      req_addr = ram_addr;
      req_din  = din;
    end
    if (accept) begin
      slot_full_next = 1'b1;
    end else if (slot_clear) begin
      slot_full_next = 1'b0;
    end else begin
      slot_full_next = slot_full;
    end
    ref_run   = !(state inside {S_INIT_WAIT, S_INIT_PRE, S_INIT_REF1, S_INIT_REF2, S_INIT_MRS});
    entering  = (next_state != state);
    ref_enter = (next_state == S_REFRESH) & (state != S_REFRESH);
  end

  // State register with per-state cycle counter
  always_ff @(posedge mclk28 or posedge reset_in) begin
    if (reset_in) begin
      state  <= S_INIT_WAIT;
      tcnt   <= 16'd0;
      acc_we <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state != state) begin
        tcnt <= 16'd0;
      end else begin
        tcnt <= tcnt + 16'd1;
      end
      if (state == S_RW) begin
        acc_we <= slot_we;
      end else begin
        acc_we <= acc_we;
      end
    end
  end

  // Next-state logic; refresh wins over a pending request in IDLE
  always_comb begin
    next_state = state;
    case (state)
      S_INIT_WAIT: if (tcnt == WAIT_LAST) next_state = S_INIT_PRE;  else next_state = state;
      S_INIT_PRE:  if (tcnt == 16'd1)     next_state = S_INIT_REF1; else next_state = state;
      S_INIT_REF1: if (tcnt == 16'd3)     next_state = S_INIT_REF2; else next_state = state;
      S_INIT_REF2: if (tcnt == 16'd3)     next_state = S_INIT_MRS;  else next_state = state;
      S_INIT_MRS:  if (tcnt == 16'd2)     next_state = S_IDLE;      else next_state = state;
      S_IDLE: begin
        if (ref_pend) begin
          next_state = S_REFRESH;
        end else if (slot_full | accept) begin
          next_state = S_ACT;
        end else begin
          next_state = S_IDLE;
        end
      end
      S_ACT:  next_state = S_TRCD;
      S_TRCD: next_state = S_RW;
      S_RW: begin
        if (slot_we) next_state = S_RECOVER;
        else         next_state = S_CL1;
      end
      S_CL1: next_state = S_CL2;
      S_CL2: next_state = S_RECOVER;
      // writes need an extra cycle for write recovery before the auto-precharge completes
      S_RECOVER: begin
        if (!acc_we || tcnt == 16'd1) next_state = S_IDLE;
        else                          next_state = S_RECOVER;
      end
      S_REFRESH: begin
        if (tcnt != 16'd3)            next_state = S_REFRESH;
        else if (slot_full | accept)  next_state = S_ACT;
        else                          next_state = S_IDLE;
      end
      default: next_state = S_INIT_WAIT;
    endcase
  end

  // SDRAM pin values for the cycle being entered, registered below
  always_comb begin
    cmd_next    = CMD_NOP;
    addr_next   = 13'h0000;
    dqm_next    = 2'b11;
    dq_out_next = 16'h0000;
    dq_oe_next  = 1'b0;
    busy_next   = ~((next_state == S_IDLE) & ~slot_full_next);
    case (next_state)
      S_INIT_PRE: begin
        if (entering) begin
          cmd_next  = CMD_PRE;
          addr_next = 13'h0400;
        end else begin
          cmd_next  = CMD_NOP;
        end
      end
      S_INIT_REF1, S_INIT_REF2, S_REFRESH: begin
        if (entering) cmd_next = CMD_REF;
        else          cmd_next = CMD_NOP;
      end
      S_INIT_MRS: begin
        if (entering) begin
          cmd_next  = CMD_MRS;
          addr_next = MODE_WORD;
        end else begin
          cmd_next  = CMD_NOP;
        end
      end
      S_ACT: begin
        cmd_next  = CMD_ACT;
        addr_next = {4'b0000, req_addr[17:9]};
      end
      S_RW: begin
        addr_next = {2'b00, 1'b1, 2'b00, req_addr[8:1]};
        if (req_we) begin
          cmd_next    = CMD_WRITE;
          dq_out_next = {req_din, req_din};
          dq_oe_next  = 1'b1;
          dqm_next    = req_addr[0] ? 2'b01 : 2'b10;
        end else begin
          cmd_next    = CMD_READ;
          dqm_next    = 2'b00;
        end
      end
      S_CL1, S_CL2: dqm_next = 2'b00;
      default:      cmd_next = CMD_NOP;
    endcase
  end

  // Registered SDRAM pins, busy and ready
  always_ff @(posedge mclk28 or posedge reset_in) begin
    if (reset_in) begin
      cmd_reg   <= CMD_DESEL;
      sd_cke    <= 1'b1;
      sd_addr   <= 13'h0000;
      sd_dqm    <= 2'b11;
      sd_dq_out <= 16'h0000;
      sd_dq_oe  <= 1'b0;
      busy      <= 1'b1;
      ready     <= 1'b0;
    end else begin
      cmd_reg   <= cmd_next;
      sd_cke    <= 1'b1;
      sd_addr   <= addr_next;
      sd_dqm    <= dqm_next;
      sd_dq_out <= dq_out_next;
      sd_dq_oe  <= dq_oe_next;
      busy      <= busy_next;
      if (next_state == S_IDLE) ready <= 1'b1;
      else                      ready <= ready;
    end
  end

  // One-deep request slot and sticky overrun flag
  always_ff @(posedge mclk28 or posedge reset_in) begin
    if (reset_in) begin
      slot_full <= 1'b0;
      slot_we   <= 1'b0;
      slot_addr <= 18'h00000;
      slot_din  <= 8'h00;
      overrun   <= 1'b0;
    end else begin
      slot_full <= slot_full_next;
      if (accept) begin
        slot_we   <= card_ram_we;
        slot_addr <= ram_addr;
        slot_din  <= din;
      end else begin
        slot_we   <= slot_we;
        slot_addr <= slot_addr;
        slot_din  <= slot_din;
      end
      if (req_valid & ~accept) overrun <= 1'b1;
      else                     overrun <= overrun;
    end
  end

  // Refresh interval counter, started once init is complete
  always_ff @(posedge mclk28 or posedge reset_in) begin
    if (reset_in) begin
      ref_cnt  <= 16'd0;
      ref_pend <= 1'b0;
    end else if (ref_enter) begin
      ref_cnt  <= 16'd0;
      ref_pend <= 1'b0;
    end else if (ref_run) begin
      if (ref_cnt == REF_LAST) begin
        ref_pend <= 1'b1;
      end else begin
        ref_cnt  <= ref_cnt + 16'd1;
      end
    end else begin
      ref_cnt  <= ref_cnt;
      ref_pend <= ref_pend;
    end
  end

  // Read data capture at the end of CL2
  always_ff @(posedge mclk28 or posedge reset_in) begin
    if (reset_in) begin
      dout       <= 8'h00;
      dout_valid <= 1'b0;
    end else if (state == S_CL2) begin
      dout       <= slot_addr[0] ? sd_dq_in[15:8] : sd_dq_in[7:0];
      dout_valid <= 1'b1;
    end else begin
      dout       <= dout;
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lc_sdram_seq.sv
// Directed bench for lc_sdram_seq: init sequence, byte write/read, refresh collision,
// slot overrun/accept-on-clear, ignored strobes and reset during an access.
module tb_lc_sdram_seq;

  localparam int INIT_WAIT = 2800;
  localparam logic [3:0] C_DESEL = 4'b1111;
  localparam logic [3:0] C_NOP   = 4'b0111;
  localparam logic [3:0] C_ACT   = 4'b0011;
  localparam logic [3:0] C_READ  = 4'b0101;
  localparam logic [3:0] C_WRITE = 4'b0100;
  localparam logic [3:0] C_PRE   = 4'b0010;
  localparam logic [3:0] C_REF   = 4'b0001;
  localparam logic [3:0] C_MRS   = 4'b0000;

  logic        mclk28 = 1'b0;
  logic        reset_in;
  logic        strobe;
  logic [17:0] ram_addr;
  logic        card_ram_we;
  logic        card_ram_rd;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        busy;
  logic        ready;
  logic        overrun;
  logic        sd_cke;
  logic        sd_cs_n;
  logic        sd_ras_n;
  logic        sd_cas_n;
  logic        sd_we_n;
  logic [1:0]  sd_ba;
  logic [12:0] sd_addr;
  logic [1:0]  sd_dqm;
  logic [15:0] sd_dq_out;
  logic        sd_dq_oe;
  logic [15:0] sd_dq_in;

  int total = 0;
  int bad   = 0;
  int n;

  always #5 mclk28 = ~mclk28;

  lc_sdram_seq dut (
    .mclk28(mclk28), .reset_in(reset_in), .strobe(strobe), .ram_addr(ram_addr),
    .card_ram_we(card_ram_we), .card_ram_rd(card_ram_rd), .din(din),
    .dout(dout), .dout_valid(dout_valid), .busy(busy), .ready(ready), .overrun(overrun),
    .sd_cke(sd_cke), .sd_cs_n(sd_cs_n), .sd_ras_n(sd_ras_n), .sd_cas_n(sd_cas_n),
    .sd_we_n(sd_we_n), .sd_ba(sd_ba), .sd_addr(sd_addr), .sd_dqm(sd_dqm),
    .sd_dq_out(sd_dq_out), .sd_dq_oe(sd_dq_oe), .sd_dq_in(sd_dq_in)
  );

  function automatic logic [3:0] cmd();
    return {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n};
  endfunction

  function automatic logic [3:0] exp_init(input int k);
    case (k)
      1, 5:    return C_REF;
      9:       return C_MRS;
      default: return C_NOP;
    endcase
  endfunction

  task automatic cyc();
    @(negedge mclk28);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic we, input logic rd, input logic [17:0] a, input logic [7:0] d);
    strobe = 1'b1; card_ram_we = we; card_ram_rd = rd; ram_addr = a; din = d;
  endtask

  task automatic clr_req();
    strobe = 1'b0; card_ram_we = 1'b0; card_ram_rd = 1'b0;
  endtask

  // Called right after reset_in drops on a falling edge; returns in the first IDLE cycle
  task automatic run_init();
    int  cnt;
    logic seen_dv;
    cnt = 0;
    seen_dv = 1'b0;
    do begin
      cyc();
      cnt++;
      if (dout_valid) seen_dv = 1'b1;
    end while (cmd() != C_PRE && cnt < 4000);
    chk("init_wait_len", 32'(cnt), 32'(INIT_WAIT));
    chk("init_no_dv", 32'(seen_dv), 32'h0);
    chk("init_pre_a10", 32'(sd_addr[10]), 32'h1);
    for (int k = 0; k < 12; k++) begin
      cyc();
      chk("init_seq", 32'(cmd()), 32'(exp_init(k)));
      if (k == 9)  chk("init_mrs_addr", 32'(sd_addr), 32'h020);
      if (k == 11) chk("init_ready_low", 32'(ready), 32'h0);
    end
    cyc();
    chk("init_ready", 32'(ready), 32'h1);
    chk("init_idle_busy", 32'(busy), 32'h0);
    chk("init_idle_nop", 32'(cmd()), 32'(C_NOP));
  endtask

  task automatic do_read(input logic [17:0] a, input logic [12:0] row, input logic [12:0] col_cmd,
                         input logic [15:0] dq, input logic [7:0] exp_byte);
    set_req(1'b0, 1'b1, a, 8'h00);
    cyc(); clr_req();
    chk("rd_act", 32'(cmd()), 32'(C_ACT));
    chk("rd_row", 32'(sd_addr), 32'(row));
    cyc();
    chk("rd_trcd", 32'(cmd()), 32'(C_NOP));
    cyc();
    chk("rd_cmd", 32'(cmd()), 32'(C_READ));
    chk("rd_col", 32'(sd_addr), 32'(col_cmd));
    chk("rd_dqm", 32'(sd_dqm), 32'h0);
    chk("rd_oe", 32'(sd_dq_oe), 32'h0);
    cyc();
    chk("rd_dv_cl1", 32'(dout_valid), 32'h0);
    cyc();
    sd_dq_in = dq;
    chk("rd_dv_cl2", 32'(dout_valid), 32'h0);
    cyc();
    sd_dq_in = 16'h0000;
    chk("rd_dv", 32'(dout_valid), 32'h1);
    chk("rd_dout", 32'(dout), 32'(exp_byte));
    cyc();
    chk("rd_dv_end", 32'(dout_valid), 32'h0);
    chk("rd_dout_hold", 32'(dout), 32'(exp_byte));
    chk("rd_idle", 32'(busy), 32'h0);
  endtask

  initial begin
    reset_in = 1'b1;
    clr_req();
    ram_addr = 18'h00000;
    din = 8'h00;
    sd_dq_in = 16'h0000;
    repeat (3) cyc();
    chk("rst_cmd", 32'(cmd()), 32'(C_DESEL));
    chk("rst_cke", 32'(sd_cke), 32'h1);
    chk("rst_addr", 32'(sd_addr), 32'h0);
    chk("rst_dqm", 32'(sd_dqm), 32'h3);
    chk("rst_oe", 32'(sd_dq_oe), 32'h0);
    chk("rst_ba", 32'(sd_ba), 32'h0);
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_dv", 32'(dout_valid), 32'h0);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h1);
    chk("rst_overrun", 32'(overrun), 32'h0);
    cyc();
    reset_in = 1'b0;
    run_init();

    // write A5 to lane 1
    set_req(1'b1, 1'b0, 18'h1D3C1, 8'hA5);
    cyc(); clr_req();
    chk("wr_act", 32'(cmd()), 32'(C_ACT));
    chk("wr_row", 32'(sd_addr), 32'h0E9);
    cyc();
    chk("wr_trcd", 32'(cmd()), 32'(C_NOP));
    cyc();
    chk("wr_cmd", 32'(cmd()), 32'(C_WRITE));
    chk("wr_col", 32'(sd_addr), 32'h04E0);
    chk("wr_dq", 32'(sd_dq_out), 32'hA5A5);
    chk("wr_dqm", 32'(sd_dqm), 32'h1);
    chk("wr_oe", 32'(sd_dq_oe), 32'h1);
    cyc();
    chk("wr_rec_oe", 32'(sd_dq_oe), 32'h0);
    chk("wr_rec_cmd", 32'(cmd()), 32'(C_NOP));
    cyc();
    chk("wr_rec_busy", 32'(busy), 32'h1);
    cyc();
    chk("wr_idle", 32'(busy), 32'h0);

    do_read(18'h1D3C0, 13'h0E9, 13'h04E0, 16'h5A3C, 8'h3C);
    do_read(18'h1D3C1, 13'h0E9, 13'h04E0, 16'h5A3C, 8'h5A);

    // lock onto the refresh cadence, then strobe exactly when ref_pend rises
    n = 0;
    do begin
      cyc();
      n++;
    end while (cmd() != C_REF && n < 400);
    chk("ref_seen", 32'(cmd()), 32'(C_REF));
    repeat (210) cyc();
    set_req(1'b1, 1'b0, 18'h00005, 8'h3C);
    cyc(); clr_req();
    chk("col_ref", 32'(cmd()), 32'(C_REF));
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("col_ref_nop", 32'(cmd()), 32'(C_NOP));
    end
    cyc();
    chk("col_act", 32'(cmd()), 32'(C_ACT));
    chk("col_row", 32'(sd_addr), 32'h0);
    chk("col_overrun", 32'(overrun), 32'h0);
    cyc(); cyc();
    chk("col_wr", 32'(cmd()), 32'(C_WRITE));
    chk("col_col", 32'(sd_addr), 32'h0402);
    chk("col_dqm", 32'(sd_dqm), 32'h1);
    cyc(); cyc(); cyc();
    chk("col_idle", 32'(busy), 32'h0);

    // strobe on the cycle the slot frees is taken
    set_req(1'b1, 1'b0, 18'h02002, 8'h11);
    cyc(); clr_req();
    chk("acc_act1", 32'(cmd()), 32'(C_ACT));
    chk("acc_row1", 32'(sd_addr), 32'h010);
    cyc(); cyc();
    chk("acc_wr1", 32'(cmd()), 32'(C_WRITE));
    chk("acc_col1", 32'(sd_addr), 32'h0401);
    chk("acc_dq1", 32'(sd_dq_out), 32'h1111);
    chk("acc_dqm1", 32'(sd_dqm), 32'h2);
    set_req(1'b1, 1'b0, 18'h04004, 8'h22);
    cyc(); clr_req();
    chk("acc_rec1", 32'(cmd()), 32'(C_NOP));
    cyc(); cyc();
    chk("acc_idle_nop", 32'(cmd()), 32'(C_NOP));
    chk("acc_idle_busy", 32'(busy), 32'h1);
    cyc();
    chk("acc_act2", 32'(cmd()), 32'(C_ACT));
    chk("acc_row2", 32'(sd_addr), 32'h020);
    chk("acc_overrun", 32'(overrun), 32'h0);
    cyc(); cyc();
    chk("acc_wr2", 32'(cmd()), 32'(C_WRITE));
    chk("acc_col2", 32'(sd_addr), 32'h0402);
    chk("acc_dq2", 32'(sd_dq_out), 32'h2222);
    chk("acc_dqm2", 32'(sd_dqm), 32'h2);
    cyc(); cyc(); cyc();
    chk("acc_idle", 32'(busy), 32'h0);

    // second strobe two cycles later is dropped
    set_req(1'b0, 1'b1, 18'h00100, 8'h00);
    cyc(); clr_req();
    chk("ovr_act", 32'(cmd()), 32'(C_ACT));
    cyc();
    chk("ovr_before", 32'(overrun), 32'h0);
    set_req(1'b1, 1'b0, 18'h00200, 8'h77);
    cyc(); clr_req();
    chk("ovr_read", 32'(cmd()), 32'(C_READ));
    chk("ovr_set", 32'(overrun), 32'h1);
    cyc(); cyc(); cyc();
    chk("ovr_dv", 32'(dout_valid), 32'h1);
    chk("ovr_dout", 32'(dout), 32'h00);
    cyc();
    chk("ovr_idle", 32'(busy), 32'h0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("ovr_dropped_nop", 32'(cmd()), 32'(C_NOP));
      chk("ovr_sticky", 32'(overrun), 32'h1);
    end

    // strobe with no qualifier does nothing
    set_req(1'b0, 1'b0, 18'h00300, 8'h55);
    cyc(); clr_req();
    for (int k = 0; k < 6; k++) begin
      chk("ign_nop", 32'(cmd()), 32'(C_NOP));
      chk("ign_busy", 32'(busy), 32'h0);
      cyc();
    end

    // reset in CL1 aborts the read
    set_req(1'b0, 1'b1, 18'h1D3C0, 8'h00);
    cyc(); clr_req();
    chk("ra_act", 32'(cmd()), 32'(C_ACT));
    cyc(); cyc();
    chk("ra_read", 32'(cmd()), 32'(C_READ));
    cyc();
    chk("ra_cl1", 32'(cmd()), 32'(C_NOP));
    sd_dq_in = 16'hFFFF;
    #1 reset_in = 1'b1;
    #1;
    chk("ra_cmd", 32'(cmd()), 32'(C_DESEL));
    chk("ra_dqm", 32'(sd_dqm), 32'h3);
    chk("ra_addr", 32'(sd_addr), 32'h0);
    chk("ra_busy", 32'(busy), 32'h1);
    chk("ra_ready", 32'(ready), 32'h0);
    chk("ra_overrun", 32'(overrun), 32'h0);
    chk("ra_dout", 32'(dout), 32'h0);
    chk("ra_dv", 32'(dout_valid), 32'h0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("ra_dv_hold", 32'(dout_valid), 32'h0);
    end
    cyc();
    reset_in = 1'b0;
    sd_dq_in = 16'h0000;
    run_init();
    chk("ra_dout_after", 32'(dout), 32'h0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("ra_slot_empty", 32'(cmd()), 32'(C_NOP));
      chk("ra_idle_busy", 32'(busy), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lc_sdram_seq.md
# lc_sdram_seq

Memory sequencer directly downstream of the language-card / Saturn RAM-card bank logic. It takes the card's 18-bit RAM address plus its read/write qualifiers on each CPU bus strobe. It turns each strobe into a single-byte access to the board's 16-bit SDRAM and runs the power-up initialisation and periodic auto-refresh. It buffers one request so a strobe that arrives during refresh is never lost.

## Interface
Parameters:
- INIT_WAIT, 2800: power-up settle delay, in mclk28 cycles (≈100 µs).
- REF_INTERVAL, 210: cycles between auto-refresh requests (≈7.5 µs).
- MODE_WORD, 13'h020: SDRAM mode register value (CL=2, burst 1, sequential).

Ports (one clock; reset is asynchronous and active-high):
- mclk28  in  1  system clock, all logic on rising edge
- reset_in  in  1  asynchronous, active-high reset
- strobe  in  1  one-cycle request pulse from bus timing
- ram_addr  in  18  byte address; [17:9] row, [8:1] column, [0] byte lane
- card_ram_we  in  1  write qualifier
- card_ram_rd  in  1  read qualifier
- din  in  8  write data, sampled with strobe
- dout  out  8  read data, held until next read completes
- dout_valid  out  1  one-cycle pulse when dout updates
- busy  out  1  request pending or in flight
- ready  out  1  init sequence complete
- overrun  out  1  sticky: strobe dropped because the slot was full
- sd_cke  out  1  SDRAM clock enable
- sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n  out  1 each  SDRAM command
- sd_ba  out  2  bank, always 2'b00
- sd_addr  out  13  row/column/mode address
- sd_dqm  out  2  byte masks
- sd_dq_out  out  16  write data
- sd_dq_oe  out  1  drive enable for DQ
- sd_dq_in  in  16  read data

## Operation
- Request capture: on strobe with card_ram_we=1 (write), or with card_ram_rd=1 and card_ram_we=0 (read), latch addr/din/type into a one-deep slot. Strobe with both qualifiers low is ignored. If the slot is full, the new strobe is dropped and overrun sets. Overrun clears only on reset.
- Command encoding {cs_n,ras_n,cas_n,we_n}:
  - NOP 0111
  - ACT 0011
  - READ 0101
  - WRITE 0100
  - PRE 0010
  - REF 0001
  - MRS 0000
- States:
  - INIT_WAIT: count INIT_WAIT cycles, issue NOP.
  - INIT_PRE: issue PRE with sd_addr[10]=1, then 1 NOP.
  - INIT_REF1 and INIT_REF2: each issues REF, then 3 NOP.
  - INIT_MRS: issue MRS with sd_addr=MODE_WORD, then 2 NOP.
  - IDLE: ready rises on the first cycle in IDLE.
  - ACT, TRCD, RW, CL1, CL2, RECOVER.
  - REFRESH: REF, then 3 NOP.
- Refresh counter runs from leaving INIT_MRS and sets ref_pend at REF_INTERVAL. Entering REFRESH clears ref_pend and reloads the counter.
- In IDLE with both ref_pend and slot full, refresh goes first. A request waits at most 4 cycles.
- Access sequence:
  - ACT with sd_addr={4'b0,row}.
  - TRCD NOP.
  - RW issues READ/WRITE with auto-precharge: sd_addr={2'b0,1'b1,2'b0,column}.
  - Read: NOP in CL1 and CL2. Sample sd_dq_in at the end of CL2, select byte [15:8] if ram_addr[0]=1 else [7:0], register to dout.
  - Write: sd_dq_out={din,din}, sd_dq_oe=1 in RW only. sd_dqm masks the unused lane (lane 0 → 2'b10, lane 1 → 2'b01). Reads use dqm=2'b00.
- Slot clears on entering RECOVER. busy = slot full or state ≠ IDLE/REFRESH-free, i.e. busy low only in IDLE with empty slot.

## Timing
- Reset values:
  - Command deselect (cs_n=1, others 1), sd_cke=1, sd_addr=0, sd_dqm=2'b11, sd_dq_oe=0.
  - dout=0, dout_valid=0, ready=0, busy=1, overrun=0.
  - State INIT_WAIT, slot empty.
- Reset asserted mid-access aborts immediately to INIT_WAIT. The full init sequence reruns.
- Read latency: strobe at cycle 0 in IDLE → ACT at cycle 1, READ at 3, dout_valid at cycle 6. Back in IDLE at cycle 7.
- Write: ACT at cycle 1, WRITE at 3, RECOVER at 4–5, IDLE at cycle 6.
- A strobe coinciding with the cycle the slot clears is accepted (no overrun).
- Strobes before ready=1 are captured into the slot and served after init.

## Test plan
- Reset release → NOP for 2800 cycles, then PRE (addr[10]=1), REF, REF, MRS with sd_addr=13'h020. ready=1 one cycle after the final MRS NOP.
- Write 8'hA5 to ram_addr=18'h1D3C1 → ACT row 9'h0E9, WRITE col 8'h E0 with addr[10]=1, dq_out=16'hA5A5, dqm=2'b01.
- Read ram_addr=18'h1D3C0, driving sd_dq_in=16'h5A3C during CL2 → dout=8'h3C, dout_valid pulses exactly 6 cycles after strobe.
- Strobe on the same cycle ref_pend sets → REF issued first, ACT follows 4 cycles later, overrun stays 0.
- Two strobes 2 cycles apart → second dropped, overrun=1. A strobe with both qualifiers 0 → no commands issued.
- reset_in pulsed during CL1 → outputs return to reset values asynchronously, dout_valid never pulses, init sequence restarts.
